// File: rtl/sync_fifo_vr.sv
// Single-clock FIFO with valid/ready on both sides, first-word-fall-through read,
// fill level, programmable almost-full/almost-empty flags and synchronous flush.
module sync_fifo_vr #(
  parameter  int DATA_W     = 8,
  parameter  int DEPTH      = 8,
  parameter  int AFULL_LVL  = DEPTH - 2,
  parameter  int AEMPTY_LVL = 1,
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  level,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_vr: DEPTH must be a power of two >= 2");
  end
  if ((AFULL_LVL < 1) || (AFULL_LVL > DEPTH)) begin : g_bad_afull
    $error("sync_fifo_vr: AFULL_LVL must lie in 1..DEPTH");
  end
  if ((AEMPTY_LVL < 0) || (AEMPTY_LVL > DEPTH - 1)) begin : g_bad_aempty
    $error("sync_fifo_vr: AEMPTY_LVL must lie in 0..DEPTH-1");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_push;
  logic              w_pop;

  // Every flag decodes the registered level, so in_ready never depends on out_ready.
  assign full         = (r_level == LVL_W'(DEPTH));
  assign empty        = (r_level == '0);
  assign almost_full  = (r_level >= LVL_W'(AFULL_LVL));
  assign almost_empty = (r_level <= LVL_W'(AEMPTY_LVL));
  assign in_ready     = !full;
  assign out_valid    = !empty;
  assign out_data     = r_mem[r_rd_ptr];
  assign level        = r_level;

  assign w_push = in_valid && in_ready && !flush && !rst;
  assign w_pop  = out_valid && out_ready && !flush && !rst;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_sync_fifo_vr.sv
// Drives a DEPTH=4 and a DEPTH=8 FIFO with shared stimulus and checks both
// against queue-based reference models every cycle.
module tb_sync_fifo_vr;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       inValid;
  logic [7:0] inData;
  logic       outReady;

  logic       inReady4, outValid4, aFull4, aEmpty4, full4, empty4;
  logic [7:0] outData4;
  logic [2:0] level4;
  logic       inReady8, outValid8, aFull8, aEmpty8, full8, empty8;
  logic [7:0] outData8;
  logic [3:0] level8;

  logic [7:0] q4[$];
  logic [7:0] q8[$];
  int         nChecks = 0;
  int         nFails  = 0;
  logic       armed   = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_vr #(.DATA_W(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_data(inData), .in_ready(inReady4),
    .out_valid(outValid4), .out_data(outData4), .out_ready(outReady),
    .level(level4), .almost_full(aFull4), .almost_empty(aEmpty4),
    .full(full4), .empty(empty4)
  );

  sync_fifo_vr #(.DATA_W(8), .DEPTH(8), .AFULL_LVL(6), .AEMPTY_LVL(1)) u_dut8 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_data(inData), .in_ready(inReady8),
    .out_valid(outValid8), .out_data(outData8), .out_ready(outReady),
    .level(level8), .almost_full(aFull8), .almost_empty(aEmpty8),
    .full(full8), .empty(empty8)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue per FIFO; accepted words enter at the back at the
  // edge they are accepted, and leave from the front when consumed.
  always @(posedge clk) begin
    automatic bit push4 = inValid && (q4.size() < 4);
    automatic bit pop4  = outReady && (q4.size() > 0);
    automatic bit push8 = inValid && (q8.size() < 8);
    automatic bit pop8  = outReady && (q8.size() > 0);
    if (rst || flush) begin
      q4.delete();
      q8.delete();
    end else begin
      if (pop4) void'(q4.pop_front());
      if (push4) q4.push_back(inData);
      if (pop8) void'(q8.pop_front());
      if (push8) q8.push_back(inData);
    end
  end

  // Monitor: mid-cycle comparison of every DUT output with the model.
  always @(negedge clk) begin
    if (armed) begin
      checkOutput("d4 level",        32'(level4),    32'(q4.size()));
      checkOutput("d4 out_valid",    32'(outValid4), 32'(q4.size() != 0));
      checkOutput("d4 in_ready",     32'(inReady4),  32'(q4.size() != 4));
      checkOutput("d4 full",         32'(full4),     32'(q4.size() == 4));
      checkOutput("d4 empty",        32'(empty4),    32'(q4.size() == 0));
      checkOutput("d4 almost_full",  32'(aFull4),    32'(q4.size() >= 2));
      checkOutput("d4 almost_empty", 32'(aEmpty4),   32'(q4.size() <= 1));
      if (q4.size() > 0) checkOutput("d4 out_data", 32'(outData4), 32'(q4[0]));
      checkOutput("d8 level",        32'(level8),    32'(q8.size()));
      checkOutput("d8 out_valid",    32'(outValid8), 32'(q8.size() != 0));
      checkOutput("d8 in_ready",     32'(inReady8),  32'(q8.size() != 8));
      checkOutput("d8 full",         32'(full8),     32'(q8.size() == 8));
      checkOutput("d8 empty",        32'(empty8),    32'(q8.size() == 0));
      checkOutput("d8 almost_full",  32'(aFull8),    32'(q8.size() >= 6));
      checkOutput("d8 almost_empty", 32'(aEmpty8),   32'(q8.size() <= 1));
      if (q8.size() > 0) checkOutput("d8 out_data", 32'(outData8), 32'(q8[0]));
    end
  end

  task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic ordy,
                               input logic fl, input logic rs);
    inValid  = iv;
    inData   = d;
    outReady = ordy;
    flush    = fl;
    rst      = rs;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] pat [5];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44; pat[4] = 8'h55;

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    armed = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Fill past full with the consumer stalled, then drain.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, pat[i], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Single word into an empty FIFO falls through next cycle.
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Streaming at level 2 with both sides active; pointers wrap repeatedly.
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h03 + i), 1'b1, 1'b0, 1'b0);

    // Full DEPTH=4: simultaneous push and pop must only pop.
    applyStimulus(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC4, 1'b1, 1'b0, 1'b0);

    // Flush with a push at level 3, then reset mid-fill, then a fresh word.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEF, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Threshold sweep: fill 0 -> 8, then drain 8 -> 0.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Randomised phases: filling bias, draining bias, balanced.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 600; i++) begin
        automatic int pIn  = (ph == 0) ? 80 : (ph == 1) ? 30 : 55;
        automatic int pOut = (ph == 0) ? 30 : (ph == 1) ? 80 : 55;
        applyStimulus($urandom_range(0, 99) < pIn,
                      8'($urandom),
                      $urandom_range(0, 99) < pOut,
                      $urandom_range(0, 199) == 0,
                      $urandom_range(0, 399) == 0);
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
